// File: rtl/cache_mem_responder_if.sv
// Cache-side bus between the I/D caches (master) and the memory responder (slave):
// read request / beat return channel plus a single-cycle write channel carrying a full line.
interface cache_mem_responder_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Main-memory endpoint for the cache bus: word/half/byte and line reads/writes served from an
// internal word RAM split into one bank per line word. Optional MEM_STALL_EN adds LFSR back-pressure.
module cache_mem_responder #(
    parameter int unsigned MEM_WORDS  = 16384,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rstn,
    cache_mem_responder_if.slave  bus
);

    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam int          LAT_W      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned BANK_DEPTH = MEM_WORDS / LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [LAT_W-1:0]   w_lat_next;
    logic [1:0]         r_beat;
    logic [1:0]         w_beat_next;
    logic [1:0]         r_last_beat;
    logic [1:0]         w_last_next;
    logic [IDX_W-1:0]   r_base;
    logic [IDX_W-1:0]   w_base_next;
    logic               r_rdy;

    logic               w_stall_rdy;
    logic               w_stall_beat;
    logic               w_rd_rdy;
    logic               w_wr_rdy;
    logic               w_ret_valid;
    logic               w_ret_last;
    logic               w_rd_fire;
    logic               w_wr_fire;

    logic               w_rd_line;
    logic               w_wr_line;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_ram_idx;
    logic [1:0]         r_rd_bank;
    logic [31:0]        w_bank_q [LINE_WORDS];
    logic [31:0]        w_rd_q;
    logic               w_unused_addr;

    // Only the line encoding is special; every other type (reserved ones included) is one word.
    assign w_rd_line = (bus.rd_type == 3'b100);
    assign w_wr_line = (bus.wr_type == 3'b100);
    assign w_rd_idx  = bus.rd_addr[IDX_W+1:2];
    assign w_wr_idx  = bus.wr_addr[IDX_W+1:2];
    assign w_unused_addr = &{1'b0, bus.rd_addr[31:IDX_W+2], bus.rd_addr[1:0],
                             bus.wr_addr[31:IDX_W+2], bus.wr_addr[1:0]};

`ifdef MEM_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_stall_rdy  = r_lfsr[0];
    assign w_stall_beat = r_lfsr[1];
`else
    logic [15:0] w_unused_seed;

    assign w_unused_seed = LFSR_SEED;
    assign w_stall_rdy   = 1'b0;
    assign w_stall_beat  = 1'b0;
`endif

    assign w_rd_fire = bus.rd_req & w_rd_rdy;
    assign w_wr_fire = bus.wr_req & w_wr_rdy;

    // r_rdy keeps ready low for the first cycle out of reset and whenever a read is in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_base      <= '0;
            r_rdy       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lat_cnt   <= w_lat_next;
            r_beat      <= w_beat_next;
            r_last_beat <= w_last_next;
            r_base      <= w_base_next;
            r_rdy       <= (w_state_next == ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lat_next   = r_lat_cnt;
        w_beat_next  = r_beat;
        w_last_next  = r_last_beat;
        w_base_next  = r_base;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_fire) begin
                    w_state_next = ST_RD_WAIT;
                    w_lat_next   = LAT_W'(RD_LATENCY - 1);
                    w_beat_next  = 2'd0;
                    w_base_next  = w_rd_line ? {w_rd_idx[IDX_W-1:2], 2'b00} : w_rd_idx;
                    w_last_next  = w_rd_line ? 2'd3 : 2'd0;
                end
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_next = ST_RD_BURST;
                end else begin
                    w_lat_next = r_lat_cnt - LAT_W'(1);
                end
            end
            ST_RD_BURST: begin
                if (w_ret_valid) begin
                    if (r_beat == r_last_beat) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beat_next = r_beat + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wr_rdy    = r_rdy && (r_state == ST_IDLE) && !w_stall_rdy;
        w_rd_rdy    = w_wr_rdy && !bus.wr_req;
        w_ret_valid = (r_state == ST_RD_BURST) && !w_stall_beat;
        w_ret_last  = w_ret_valid && (r_beat == r_last_beat);
    end

    assign bus.wr_rdy    = w_wr_rdy;
    assign bus.rd_rdy    = w_rd_rdy;
    assign bus.ret_valid = w_ret_valid;
    assign bus.ret_last  = w_ret_last;
    assign bus.ret_data  = w_ret_valid ? w_rd_q : 32'h0;

    // Read port looks one beat ahead so the registered RAM output already holds the beat shown.
    assign w_rd_ram_idx = {r_base[IDX_W-1:2], r_base[1:0] + w_beat_next};

    always_ff @(posedge clk) begin
        r_rd_bank <= w_rd_ram_idx[1:0];
    end

    assign w_rd_q = w_bank_q[r_rd_bank];

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
            logic [31:0] r_mem [BANK_DEPTH];
            logic [31:0] r_q;
            logic        w_we;
            logic [3:0]  w_be;
            logic [31:0] w_wdata;

            assign w_we    = w_wr_fire && (w_wr_line || (w_wr_idx[1:0] == 2'(gi)));
            assign w_be    = w_wr_line ? 4'hF : bus.wr_wstrb;
            assign w_wdata = w_wr_line ? bus.wr_data[32*gi +: 32] : bus.wr_data[31:0];

            always_ff @(posedge clk) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_we && w_be[b]) begin
                        r_mem[w_wr_idx[IDX_W-1:2]][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
                r_q <= r_mem[w_rd_ram_idx[IDX_W-1:2]];
            end

            assign w_bank_q[gi] = r_q;
        end
    endgenerate

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed and scoreboard-checked bench for cache_mem_responder (default build or MEM_STALL_EN).
module tb_cache_mem_responder;

    localparam int unsigned MEM_WORDS  = 16384;
    localparam int unsigned RD_LATENCY = 2;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   gaps_total;
    logic [31:0] model [64];

    cache_mem_responder_if bus();

    cache_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .RD_LATENCY(RD_LATENCY)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        bus.wr_req   = 1'b1;
        bus.wr_type  = t;
        bus.wr_addr  = a;
        bus.wr_wstrb = s;
        bus.wr_data  = d;
        #1;
        while (!bus.wr_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_wr_rdy"}, {31'b0, bus.wr_rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        $display("wr %s type=%b addr=%h strb=%b data=%h", tag, t, a, s, d);
    endtask

    // Called #1 after the accept edge; collects beats until the expected count or the budget.
    task automatic collect(input logic [127:0] ev, input int nb, input string tag);
        int k;
        int cyc;
        int first;
        int prev;
        int gaps;
        k = 0; cyc = 0; first = 0; prev = 0; gaps = 0;
        while (k < nb && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ret_valid) begin
                if (k == 0) first = cyc;
                else if (cyc != prev + 1) gaps++;
                chk($sformatf("%s_d%0d", tag, k), bus.ret_data, ev[32*k +: 32]);
                chk($sformatf("%s_last%0d", tag, k), {31'b0, bus.ret_last}, {31'b0, k == nb - 1});
                prev = cyc;
                k++;
            end
        end
        chk({tag, "_beats"}, k, nb);
        gaps_total += gaps;
`ifndef MEM_STALL_EN
        chk({tag, "_latency"}, first, RD_LATENCY);
        chk({tag, "_gaps"}, gaps, 0);
`endif
        @(posedge clk);
        #1;
        chk({tag, "_no_extra_beat"}, {31'b0, bus.ret_valid}, 32'd0);
`ifndef MEM_STALL_EN
        chk({tag, "_rdy_after_last"}, {31'b0, bus.rd_rdy}, 32'd1);
`endif
        $display("rd %s beats=%0d first_beat_cycle=%0d gaps=%0d", tag, k, first, gaps);
    endtask

    task automatic issue_read(input logic [2:0] t, input logic [31:0] a, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_type = t;
        bus.rd_addr = a;
        #1;
        while (!bus.rd_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_rd_rdy"}, {31'b0, bus.rd_rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a, input logic [127:0] ev,
                           input int nb, input string tag);
        issue_read(t, a, tag);
        collect(ev, nb, tag);
    endtask

    localparam logic [127:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] D3 = 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000;
    localparam logic [127:0] D4 = 128'h0404_0404_0303_0303_0202_0202_0101_0101;
    localparam logic [127:0] D5 = 128'hFFFF_000C_FFFF_0008_FFFF_0004_FFFF_0000;

    initial begin
        int n;
        int r;
        int off;
        int lb;
        logic [31:0]  a;
        logic [3:0]   s;
        logic [127:0] d;
        logic [127:0] ev;

        total = 0; bad = 0; gaps_total = 0;
        rstn = 1'b0;
        bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = 32'h0;
        bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = 32'h0;
        bus.wr_wstrb = 4'h0; bus.wr_data = 128'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_rdy",    {31'b0, bus.rd_rdy},    32'd0);
        chk("rst_wr_rdy",    {31'b0, bus.wr_rdy},    32'd0);
        chk("rst_ret_valid", {31'b0, bus.ret_valid}, 32'd0);
        chk("rst_ret_last",  {31'b0, bus.ret_last},  32'd0);
        chk("rst_ret_data",  bus.ret_data,           32'd0);
        rstn = 1'b1;
        #1;
        chk("rel_rd_rdy_before_edge", {31'b0, bus.rd_rdy}, 32'd0);
        @(posedge clk);
        #1;
`ifndef MEM_STALL_EN
        chk("rel_rd_rdy_after_edge", {31'b0, bus.rd_rdy}, 32'd1);
        chk("rel_wr_rdy_after_edge", {31'b0, bus.wr_rdy}, 32'd1);
`endif

        // 1: line write then line read from a mid-line address
        do_write(3'b100, 32'h0000_0100, 4'h0, D1, "t1");
        do_read(3'b100, 32'h0000_0104, D1, 4, "t1_line");
        do_read(3'b100, 32'h0000_010C, D1, 4, "t1_line_c");

        // 2: word write, byte-lane merge, word read; plus sub-word and reserved types
        do_write(3'b010, 32'h0000_0200, 4'hF, {96'h0, 32'hDEAD_BEEF}, "t2_word");
        do_write(3'b000, 32'h0000_0201, 4'b0010, {96'h0, 32'h0000_5500}, "t2_byte");
        do_read(3'b010, 32'h0000_0200, {96'h0, 32'hDEAD_55EF}, 1, "t2_word");
        do_read(3'b001, 32'h0000_0202, {96'h0, 32'hDEAD_55EF}, 1, "t2_half");
        do_read(3'b000, 32'h0000_0203, {96'h0, 32'hDEAD_55EF}, 1, "t2_byte");
        do_write(3'b011, 32'h0000_0210, 4'hF, {96'h0, 32'h1234_5678}, "t2_rsv");
        do_read(3'b111, 32'h0000_0210, {96'h0, 32'h1234_5678}, 1, "t2_rsv");

        // 3: simultaneous read and write to the same line; write must win
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_type = 3'b100; bus.rd_addr = 32'h0000_0300;
        bus.wr_req = 1'b1; bus.wr_type = 3'b100; bus.wr_addr = 32'h0000_0308;
        bus.wr_wstrb = 4'h0; bus.wr_data = D3;
        #1;
        n = 0;
        while (!bus.wr_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t3_wr_rdy", {31'b0, bus.wr_rdy}, 32'd1);
        chk("t3_rd_rdy_blocked", {31'b0, bus.rd_rdy}, 32'd0);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        $display("wr t3 line addr=00000308 with competing read");
        n = 0;
        while (!bus.rd_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t3_rd_rdy", {31'b0, bus.rd_rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        collect(D3, 4, "t3_line");

        // 4: index wrap modulo MEM_WORDS
        do_write(3'b010, 32'h0000_0008, 4'hF, {96'h0, 32'hA5A5_0008}, "t4_word");
        do_read(3'b010, 4 * MEM_WORDS + 8, {96'h0, 32'hA5A5_0008}, 1, "t4_wrap_word");
        do_write(3'b100, 4 * MEM_WORDS + 32'h20, 4'h0, D4, "t4_line");
        do_read(3'b100, 32'h0000_002C, D4, 4, "t4_wrap_line");
        do_write(3'b100, 4 * MEM_WORDS - 16, 4'h0, D5, "t4_top");
        do_read(3'b100, 4 * MEM_WORDS - 8, D5, 4, "t4_top_line");

        // 5: reset during the second beat of a line read
        issue_read(3'b100, 32'h0000_0100, "t5");
        n = 0;
        r = 0;
        while (r < 2 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ret_valid) r++;
        end
        chk("t5_reached_beat2", r, 2);
        rstn = 1'b0;
        #1;
        chk("t5_abort_valid", {31'b0, bus.ret_valid}, 32'd0);
        chk("t5_abort_last",  {31'b0, bus.ret_last},  32'd0);
        chk("t5_abort_data",  bus.ret_data,           32'd0);
        chk("t5_abort_rd_rdy", {31'b0, bus.rd_rdy},   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_post_valid", {31'b0, bus.ret_valid}, 32'd0);
`ifndef MEM_STALL_EN
        chk("t5_post_rd_rdy", {31'b0, bus.rd_rdy}, 32'd1);
`endif
        $display("rst t5 applied mid-burst and released");
        do_read(3'b010, 32'h0000_0200, {96'h0, 32'hDEAD_55EF}, 1, "t5_after");

        // 6: random mixed traffic in words 0x100..0x13F against a byte-accurate model
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int w = 0; w < 4; w++) model[4*i + w] = d[32*w +: 32];
            do_write(3'b100, 32'h400 + 32'(16 * i), 4'h0, d, $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            r   = int'($urandom_range(0, 7));
            off = int'($urandom_range(0, 63));
            lb  = off & ~3;
            a   = 32'h400 + 32'(4 * off) + 32'($urandom_range(0, 3));
            d   = {$urandom, $urandom, $urandom, $urandom};
            case (r)
                0: begin
                    for (int w = 0; w < 4; w++) model[lb + w] = d[32*w +: 32];
                    do_write(3'b100, a, 4'h0, d, $sformatf("rnd%0d", i));
                end
                1, 2, 3: begin
                    s = (r == 1) ? 4'hF : (r == 2) ? (a[1] ? 4'hC : 4'h3) : (4'h1 << a[1:0]);
                    for (int b = 0; b < 4; b++) if (s[b]) model[off][8*b +: 8] = d[8*b +: 8];
                    do_write((r == 1) ? 3'b010 : (r == 2) ? 3'b001 : 3'b000, a, s, d,
                             $sformatf("rnd%0d", i));
                end
                4: begin
                    ev = {model[lb + 3], model[lb + 2], model[lb + 1], model[lb]};
                    do_read(3'b100, a, ev, 4, $sformatf("rnd%0d", i));
                end
                default: begin
                    do_read((r == 5) ? 3'b010 : (r == 6) ? 3'b001 : 3'b000, a,
                            {96'h0, model[off]}, 1, $sformatf("rnd%0d", i));
                end
            endcase
        end
`ifdef MEM_STALL_EN
        chk("stall_gaps_seen", {31'b0, gaps_total > 0}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
